alu_flags_stage: RTL and testbench
==================================

Name: alu_flags_stage

Overview:
- Execute-stage ALU directly downstream of the operand-2 barrel shifter.
- Combines Rn with the shifted operand for all 16 ARM data-processing opcodes.
- Owns the architectural NZCV flag register.
- Presents a registered result to writeback through a valid/ready handshake, and supports a flush from branch resolution.

Parameters:
- WIDTH, 32, datapath width; flag logic is defined for 32 only.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operation is present.
- in_ready  output  1  stage can accept this cycle.
- opcode  input  4  ARM DP opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV, E BIC, F MVN.
- s_bit  input  1  update flags.
- rn_value  input  32  first operand.
- shifter_out  input  32  second operand from the shifter.
- shifter_carry  input  1  shifter carry-out.
- rd_in  input  4  destination register index.
- flush  input  1  discard held result and block acceptance this cycle.
- out_valid  output  1  result register holds an operation.
- out_ready  input  1  writeback consumes this cycle.
- result  output  32  registered ALU result.
- rd_out  output  4  registered destination.
- wr_en  output  1  registered; 0 for opcodes 8–B.
- flags  output  4  registered NZCV, bit3 = N.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - out_valid = 0, result = 0, rd_out = 0, wr_en = 0, flags = 4'b0000.
  - Reset mid-transfer drops the held result; no partial flag update.
- in_ready = !flush && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- Accept = in_valid && in_ready. On accept, at the next edge:
  - result, rd_out and wr_en load.
  - out_valid = 1.
  - Latency is 1 cycle.
- No accept while out_valid && !out_ready: the output register holds. This is the stall case.
- Handshake rules:
  - out_valid && out_ready && !accept: out_valid goes to 0 at the next edge.
  - Simultaneous consume and accept: new data loads and out_valid stays 1, giving full throughput.
- flush = 1: out_valid goes to 0 at the next edge and nothing is accepted. Flags already committed by earlier accepts are not rolled back.
- Arithmetic (33-bit internal sum, C = bit 32):
  - SUB: Rn + ~Op2 + 1.
  - RSB: Op2 + ~Rn + 1.
  - ADD: Rn + Op2.
  - ADC: Rn + Op2 + C.
  - SBC: Rn + ~Op2 + C.
  - RSC: Op2 + ~Rn + C.
  - CMP as SUB; CMN as ADD.
  - C = carry-out, meaning NOT borrow for subtracts.
  - V = signed overflow: the operand signs, as fed to the adder, are equal and the result sign differs.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = shifter_carry, V unchanged. MOV and MVN ignore rn_value.
- Flags:
  - N = result[31], Z = (result == 0), for every opcode.
  - Update occurs only on accept with s_bit = 1; opcodes 8–B always update, whatever s_bit is.
  - The C used by ADC/SBC/RSC is the flags register value at the accept edge. Back-to-back flag-setting ops therefore see the previous op's flags with no hazard.
- Results for TST/TEQ/CMP/CMN are still written to result, with wr_en = 0.

Test Plan:
- Reset asserted mid-stall with out_valid = 1, flags = 4'b0110 -> out_valid = 0, flags = 0 immediately, without waiting for a clock edge.
- ADD, S = 1, Rn = 0x7FFFFFFF, Op2 = 1 -> result 0x80000000, NZCV = 1001, wr_en = 1, out_valid 1 cycle after accept.
- CMP Rn = 5, Op2 = 5 -> result 0, NZCV = 0110, wr_en = 0. Then ADC Rn = 1, Op2 = 1 -> result 3 (C = 1 consumed).
- MOV, S = 1, Op2 = 0, shifter_carry = 1, prior V = 1 -> NZCV = 0111. SUB 0 - 1 -> 0xFFFFFFFF, NZCV = 1000.
- out_ready held 0 for 3 cycles while in_valid = 1 -> in_ready = 0, result stable, flags unchanged. Release -> next op accepted in the same cycle as the consume, and out_valid stays 1.
- flush while out_valid = 1 and in_valid = 1 -> in_ready = 0 that cycle, out_valid = 0 at the next edge, flags unchanged by the blocked op.

Source files
------------

// File: rtl/alu_flags_stage.sv
// alu_flags_stage: execute-stage ALU for the 16 ARM data-processing opcodes with NZCV flags and a registered valid/ready output
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-high reset
//   in_valid_i / in_ready_o         upstream handshake (in_ready_o is combinational)
//   opcode_i, s_bit_i               DP opcode and flag-update request
//   rn_value_i, shifter_out_i       operands; shifter_carry_i is the shifter carry-out
//   rd_in_i                         destination register index
//   flush_i                         drop held result and refuse new input this cycle
//   out_valid_o / out_ready_i       downstream handshake
//   result_o, rd_out_o, wr_en_o     registered result, destination, write enable
//   flags_o                         architectural NZCV, bit 3 = N
module alu_flags_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       opcode_i,
    input  logic             s_bit_i,
    input  logic [WIDTH-1:0] rn_value_i,
    input  logic [WIDTH-1:0] shifter_out_i,
    input  logic             shifter_carry_i,
    input  logic [3:0]       rd_in_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       rd_out_o,
    output logic             wr_en_o,
    output logic [3:0]       flags_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [3:0]       flags_q, flags_d;
    logic             is_arith, sub_op, rev_op, use_c, cin, accept, cmp_op;
    logic [WIDTH-1:0] add_a, add_b, b_src, logic_res, alu_res;
    logic [WIDTH:0]   sum;
    logic             c_new, v_new;
    always_comb begin
        is_arith  = opcode_i inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB};
        sub_op    = opcode_i inside {4'h2, 4'h3, 4'h6, 4'h7, 4'hA};
        rev_op    = opcode_i inside {4'h3, 4'h7};
        use_c     = opcode_i inside {4'h5, 4'h6, 4'h7};
        cmp_op    = opcode_i[3:2] == 2'b10;
        // Every subtract is a + ~b + cin; the carry-in is 1 or the current C flag.
        add_a     = rev_op ? shifter_out_i : rn_value_i;
        b_src     = rev_op ? rn_value_i : shifter_out_i;
        add_b     = sub_op ? ~b_src : b_src;
        cin       = use_c ? flags_q[1] : sub_op;
        sum       = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};
        case (opcode_i)
            4'h1, 4'h9: logic_res = rn_value_i ^ shifter_out_i;
            4'hC:       logic_res = rn_value_i | shifter_out_i;
            4'hD:       logic_res = shifter_out_i;
            4'hE:       logic_res = rn_value_i & ~shifter_out_i;
            4'hF:       logic_res = ~shifter_out_i;
            default:    logic_res = rn_value_i & shifter_out_i;
        endcase
        alu_res   = is_arith ? sum[WIDTH-1:0] : logic_res;
        c_new     = is_arith ? sum[WIDTH] : shifter_carry_i;
        v_new     = is_arith ? (add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1])
                             : flags_q[0];
        in_ready_o = !flush_i && (!valid_q || out_ready_i);
        accept    = in_valid_i && in_ready_o;
        valid_d   = flush_i ? 1'b0 : accept ? 1'b1 : out_ready_i ? 1'b0 : valid_q;
        result_d  = accept ? alu_res : result_q;
        rd_d      = accept ? rd_in_i : rd_q;
        wr_d      = accept ? !cmp_op : wr_q;
        // Compare/test opcodes set flags regardless of the S bit.
        flags_d   = (accept && (s_bit_i || cmp_op))
                  ? {alu_res[WIDTH-1], alu_res == '0, c_new, v_new} : flags_q;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            flags_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            flags_q  <= flags_d;
        end
    end
    assign out_valid_o = valid_q;
    assign result_o    = result_q;
    assign rd_out_o    = rd_q;
    assign wr_en_o     = wr_q;
    assign flags_o     = flags_q;
endmodule

// File: tb/tb_alu_flags_stage.sv
// tb_alu_flags_stage: directed and randomized checks of alu_flags_stage against an arithmetic reference model
module tb_alu_flags_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, s_bit, shifter_carry, flush, out_valid, out_ready, wr_en;
    logic [3:0]  opcode, rd_in, rd_out, flags;
    logic [31:0] rn_value, shifter_out, result;
    int          vectors = 0;
    int          miscompares = 0;
    logic        m_valid, m_wr;
    logic [31:0] m_res;
    logic [3:0]  m_rd, m_flags;
    localparam longint MAXS = 64'sh7FFFFFFF;
    localparam longint MINS = -64'sh80000000;

    always #5 clk = ~clk;

    alu_flags_stage #(.WIDTH(32)) dut (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .opcode_i(opcode), .s_bit_i(s_bit), .rn_value_i(rn_value), .shifter_out_i(shifter_out),
        .shifter_carry_i(shifter_carry), .rd_in_i(rd_in), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .result_o(result), .rd_out_o(rd_out), .wr_en_o(wr_en), .flags_o(flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer add or subtract, flags from range checks.
    function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] rn, input logic [31:0] op2,
                                            input logic sc, input logic [3:0] f);
        longint x, y, sx, sy, k, u, s;
        logic [31:0] r, xa, ya;
        logic c, v;
        c = sc; v = f[0]; r = '0;
        case (op)
            4'h0, 4'h8: r = rn & op2;
            4'h1, 4'h9: r = rn ^ op2;
            4'hC:       r = rn | op2;
            4'hD:       r = op2;
            4'hE:       r = rn & ~op2;
            4'hF:       r = ~op2;
            default: begin
                xa = (op == 4'h3 || op == 4'h7) ? op2 : rn;
                ya = (op == 4'h3 || op == 4'h7) ? rn : op2;
                x = {32'b0, xa}; y = {32'b0, ya};
                sx = longint'($signed(xa)); sy = longint'($signed(ya));
                k = 0;
                if (op == 4'h5 && f[1]) k = 1;
                if ((op == 4'h6 || op == 4'h7) && !f[1]) k = 1;
                if (op inside {4'h4, 4'h5, 4'hB}) begin
                    u = x + y + k; s = sx + sy + k; c = u > 64'sh0FFFFFFFF;
                end else begin
                    u = x - y - k; s = sx - sy - k; c = u >= 0;
                end
                v = s > MAXS || s < MINS;
                r = u[31:0];
            end
        endcase
        return {r[31], r == 32'd0, c, v, r};
    endfunction

    task automatic check_out();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("result", result, m_res);
        chk("rd_out", 32'(rd_out), 32'(m_rd));
        chk("wr_en", 32'(wr_en), 32'(m_wr));
        chk("flags", 32'(flags), 32'(m_flags));
    endtask

    task automatic step(input logic v, input logic [3:0] op, input logic s, input logic [31:0] rn,
                        input logic [31:0] op2, input logic sc, input logic [3:0] rd,
                        input logic fl, input logic ordy);
        logic exp_rdy, acc;
        logic [35:0] r;
        in_valid = v; opcode = op; s_bit = s; rn_value = rn; shifter_out = op2;
        shifter_carry = sc; rd_in = rd; flush = fl; out_ready = ordy;
        #1;
        exp_rdy = !fl && (!m_valid || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        r = ref_alu(op, rn, op2, sc, m_flags);
        if (fl) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1; m_res = r[31:0]; m_rd = rd; m_wr = !(op >= 4'h8 && op <= 4'hB);
        end else if (ordy) m_valid = 1'b0;
        if (acc && (s || (op >= 4'h8 && op <= 4'hB))) m_flags = r[35:32];
        @(posedge clk);
        #1;
        check_out();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; in_valid = 0; opcode = 0; s_bit = 0; rn_value = 0; shifter_out = 0;
        shifter_carry = 0; rd_in = 0; flush = 0; out_ready = 0;
        m_valid = 0; m_wr = 0; m_res = 0; m_rd = 0; m_flags = 0;
        repeat (2) @(posedge clk);
        #1;
        check_out();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        step(1, 4'h4, 1, 32'h7FFFFFFF, 32'h1, 0, 4'd3, 0, 1);
        chk("add_res", result, 32'h80000000);
        chk("add_nzcv", 32'(flags), 32'b1001);
        chk("add_wr", 32'(wr_en), 32'd1);
        step(1, 4'hA, 0, 32'd5, 32'd5, 0, 4'd4, 0, 1);
        chk("cmp_res", result, 32'd0);
        chk("cmp_nzcv", 32'(flags), 32'b0110);
        chk("cmp_wr", 32'(wr_en), 32'd0);
        step(1, 4'h5, 1, 32'd1, 32'd1, 0, 4'd5, 0, 1);
        chk("adc_res", result, 32'd3);
        step(1, 4'h4, 1, 32'h7FFFFFFF, 32'h1, 0, 4'd6, 0, 1);
        step(1, 4'hD, 1, 32'hDEADBEEF, 32'h0, 1, 4'd7, 0, 1);
        chk("mov_nzcv", 32'(flags), 32'b0111);
        step(1, 4'h2, 1, 32'h0, 32'h1, 0, 4'd8, 0, 1);
        chk("sub_res", result, 32'hFFFFFFFF);
        chk("sub_nzcv", 32'(flags), 32'b1000);

        repeat (3) step(1, 4'h4, 1, 32'd10, 32'd20, 0, 4'd9, 0, 0);
        chk("stall_res", result, 32'hFFFFFFFF);
        chk("stall_nzcv", 32'(flags), 32'b1000);
        step(1, 4'h4, 1, 32'd10, 32'd20, 0, 4'd9, 0, 1);
        chk("release_res", result, 32'd30);
        chk("release_valid", 32'(out_valid), 32'd1);

        step(1, 4'hA, 1, 32'd1, 32'd2, 0, 4'd1, 1, 1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_nzcv", 32'(flags), 32'b0000);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom), pick(), pick(), 1'($urandom),
                 4'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);

        step(1, 4'hA, 0, 32'd5, 32'd5, 0, 4'd2, 0, 1);
        step(0, 4'h0, 0, 32'd0, 32'd0, 0, 4'd0, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_nzcv", 32'(flags), 32'b0110);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_nzcv", 32'(flags), 32'd0);
        chk("async_rst_res", result, 32'd0);
        chk("async_rst_wr", 32'(wr_en), 32'd0);
        m_valid = 0; m_wr = 0; m_res = 0; m_rd = 0; m_flags = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        step(1, 4'h3, 1, 32'd1, 32'd0, 0, 4'd11, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
